// File: rtl/sdram_pkg.sv
// Shared command encodings, init-state enum and counter widths
// for the SDRAM command interface (sdram_ctl_if2).
package sdram_pkg;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;

  localparam int CNT_W  = 16;
  localparam int DEBT_W = 3;
  localparam int RCNT_W = 4;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PRE,
    ST_REF,
    ST_LMR,
    ST_RUN
  } init_st_e;

endpackage

// File: rtl/sdram_ref_sched.sv
// Refresh scheduler: free-running interval timer plus refresh debt.
// Optional sticky overflow flag when SDRAM_REF_OVF_EN is defined.
module sdram_ref_sched
  import sdram_pkg::*;
#(
  parameter int REF_PER      = 1560,
  parameter int REF_DEBT_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic ack_i,
  output logic req_o,
  output logic urgent_o
`ifdef SDRAM_REF_OVF_EN
  ,
  output logic ovf_o
`endif
);

  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              req_q, urg_q;
  logic              tick, ack, at_max;

  assign tick   = en_i && (tmr_q == CNT_W'(REF_PER - 1));
  assign ack    = en_i && ack_i;
  assign at_max = (debt_q == DEBT_W'(REF_DEBT_MAX));

  always_comb begin
    tmr_d = tmr_q;
    if (tick)
      tmr_d = '0;
    else if (en_i)
      tmr_d = tmr_q + CNT_W'(1);
  end

  // A refresh issued on a tick cycle cancels that tick's debt.
  always_comb begin
    debt_d = debt_q;
    if (tick && ack)
      debt_d = debt_q;
    else if (tick) begin
      if (!at_max)
        debt_d = debt_q + DEBT_W'(1);
    end else if (ack && debt_q != '0)
      debt_d = debt_q - DEBT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      debt_q <= '0;
      req_q  <= 1'b0;
      urg_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      debt_q <= debt_d;
      req_q  <= (debt_q != '0);
      urg_q  <= at_max;
    end
  end

  assign req_o    = req_q;
  assign urgent_o = urg_q;

`ifdef SDRAM_REF_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (tick && !ack && at_max)
      ovf_q <= 1'b1;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/sdram_ctl_if2.sv
// SDRAM command interface: power-up init sequencer, command decode,
// ack shaping and refresh scheduling. Option macro: SDRAM_REF_OVF_EN.
module sdram_ctl_if2
  import sdram_pkg::*;
#(
  parameter int ASIZE        = 23,
  parameter int INIT_PER     = 1000,
  parameter int INIT_GAP     = 20,
  parameter int INIT_REF_CNT = 8,
  parameter int REF_PER      = 1560,
  parameter int REF_DEBT_MAX = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [2:0]       CMD,
  input  logic [ASIZE-1:0] ADDR,
  input  logic             CM_ACK,
  input  logic             REF_ACK,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic [ASIZE-1:0] SADDR,
  output logic             CMD_ACK,
  output logic             INIT_PRECHARGE,
  output logic             INIT_REFRESH,
  output logic             INIT_LOAD_MODE,
  output logic             INIT_DONE,
  output logic             REF_REQ,
  output logic             REF_URGENT
`ifdef SDRAM_REF_OVF_EN
  ,
  output logic             REF_OVF
`endif
);

  init_st_e          st_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              pre_q, ref_q, lmr_q, done_q;
  logic              wait_end, gap_end;

  assign wait_end = (cnt_q == CNT_W'(INIT_PER));
  assign gap_end  = (cnt_q == CNT_W'(INIT_GAP - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q   <= ST_WAIT;
      cnt_q  <= '0;
      rcnt_q <= '0;
      pre_q  <= 1'b0;
      ref_q  <= 1'b0;
      lmr_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pre_q <= 1'b0;
      ref_q <= 1'b0;
      lmr_q <= 1'b0;
      unique case (st_q)
        ST_WAIT:
          if (wait_end) begin
            cnt_q <= '0;
            st_q  <= ST_PRE;
          end else
            cnt_q <= cnt_q + CNT_W'(1);
        ST_PRE:
          if (gap_end) begin
            pre_q <= 1'b1;
            cnt_q <= '0;
            st_q  <= ST_REF;
          end else
            cnt_q <= cnt_q + CNT_W'(1);
        ST_REF:
          if (gap_end) begin
            ref_q  <= 1'b1;
            cnt_q  <= '0;
            rcnt_q <= rcnt_q + RCNT_W'(1);
            if (rcnt_q == RCNT_W'(INIT_REF_CNT - 1))
              st_q <= ST_LMR;
          end else
            cnt_q <= cnt_q + CNT_W'(1);
        ST_LMR:
          if (gap_end) begin
            lmr_q <= 1'b1;
            cnt_q <= '0;
            st_q  <= ST_RUN;
          end else
            cnt_q <= cnt_q + CNT_W'(1);
        ST_RUN:
          done_q <= 1'b1;
        default:
          st_q <= ST_WAIT;
      endcase
    end
  end

  logic             nop_q, rda_q, wra_q, ack_q;
  logic             nop_d, rda_d, wra_d;
  logic [ASIZE-1:0] saddr_q;

  // Commands are masked to NOP until init has completed.
  always_comb begin
    nop_d = 1'b1;
    rda_d = 1'b0;
    wra_d = 1'b0;
    if (done_q) begin
      nop_d = 1'b0;
      unique case (1'b1)
        (CMD == CMD_NOP):    nop_d = 1'b1;
        (CMD == CMD_READA):  rda_d = 1'b1;
        (CMD == CMD_WRITEA): wra_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      nop_q   <= 1'b0;
      rda_q   <= 1'b0;
      wra_q   <= 1'b0;
      saddr_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      nop_q   <= nop_d;
      rda_q   <= rda_d;
      wra_q   <= wra_d;
      saddr_q <= ADDR;
      ack_q   <= CM_ACK && !ack_q;
    end
  end

  sdram_ref_sched #(
    .REF_PER      (REF_PER),
    .REF_DEBT_MAX (REF_DEBT_MAX)
  ) u_ref (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .en_i     (st_q == ST_RUN),
    .ack_i    (REF_ACK),
    .req_o    (REF_REQ),
    .urgent_o (REF_URGENT)
`ifdef SDRAM_REF_OVF_EN
    ,
    .ovf_o    (REF_OVF)
`endif
  );

  assign NOP            = nop_q;
  assign READA          = rda_q;
  assign WRITEA         = wra_q;
  assign SADDR          = saddr_q;
  assign CMD_ACK        = ack_q;
  assign INIT_PRECHARGE = pre_q;
  assign INIT_REFRESH   = ref_q;
  assign INIT_LOAD_MODE = lmr_q;
  assign INIT_DONE      = done_q;

endmodule

// File: tb/tb_sdram_ctl_if2.sv
// Bench for sdram_ctl_if2: cycle-formula reference model checked
// every cycle, plus hand-computed literal points.
module tb_sdram_ctl_if2;

  localparam int AW = 12;
  localparam int P  = 10;
  localparam int G  = 4;
  localparam int R  = 2;
  localparam int RP = 8;
  localparam int DM = 2;
  localparam int TD = P + (R + 2) * G + 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [2:0]    CMD = 3'd0;
  logic [AW-1:0] ADDR = '0;
  logic          CM_ACK = 1'b0;
  logic          REF_ACK = 1'b0;
  logic          NOP, READA, WRITEA, CMD_ACK;
  logic          INIT_PRECHARGE, INIT_REFRESH, INIT_LOAD_MODE;
  logic          INIT_DONE, REF_REQ, REF_URGENT;
  logic [AW-1:0] SADDR;
`ifdef SDRAM_REF_OVF_EN
  logic          REF_OVF;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  sdram_ctl_if2 #(
    .ASIZE        (AW),
    .INIT_PER     (P),
    .INIT_GAP     (G),
    .INIT_REF_CNT (R),
    .REF_PER      (RP),
    .REF_DEBT_MAX (DM)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .CMD            (CMD),
    .ADDR           (ADDR),
    .CM_ACK         (CM_ACK),
    .REF_ACK        (REF_ACK),
    .NOP            (NOP),
    .READA          (READA),
    .WRITEA         (WRITEA),
    .SADDR          (SADDR),
    .CMD_ACK        (CMD_ACK),
    .INIT_PRECHARGE (INIT_PRECHARGE),
    .INIT_REFRESH   (INIT_REFRESH),
    .INIT_LOAD_MODE (INIT_LOAD_MODE),
    .INIT_DONE      (INIT_DONE),
    .REF_REQ        (REF_REQ),
    .REF_URGENT     (REF_URGENT)
`ifdef SDRAM_REF_OVF_EN
    ,
    .REF_OVF        (REF_OVF)
`endif
  );

  // Reference model: cycle m_c = edges since reset release.
  int            m_c = -1;
  int            m_debt = 0;
  logic          e_pre = 0, e_ref = 0, e_lmr = 0, e_done = 0;
  logic          e_nop = 0, e_rda = 0, e_wra = 0, e_ack = 0;
  logic          e_req = 0, e_urg = 0, e_ovf = 0;
  logic [AW-1:0] e_saddr = '0;

  function automatic bit f_tick(int cn);
    return cn >= TD && ((cn - TD + 1) % RP) == 0;
  endfunction

  function automatic int f_debt(int d, bit t, bit a);
    if (t && a) return d;
    if (t) return (d < DM) ? d + 1 : d;
    if (a && d > 0) return d - 1;
    return d;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_c <= -1; m_debt <= 0;
      e_pre <= 0; e_ref <= 0; e_lmr <= 0; e_done <= 0;
      e_nop <= 0; e_rda <= 0; e_wra <= 0; e_ack <= 0;
      e_req <= 0; e_urg <= 0; e_ovf <= 0; e_saddr <= '0;
    end else begin
      m_c     <= m_c + 1;
      e_pre   <= (m_c + 1) == P + G;
      e_ref   <= (m_c + 1) >= P + 2 * G
              && (m_c + 1) <= P + (R + 1) * G
              && ((m_c + 1 - P) % G) == 0;
      e_lmr   <= (m_c + 1) == P + (R + 2) * G;
      e_done  <= (m_c + 1) >= TD;
      e_nop   <= !e_done || CMD == 3'd0;
      e_rda   <= e_done && CMD == 3'd1;
      e_wra   <= e_done && CMD == 3'd2;
      e_saddr <= ADDR;
      e_ack   <= CM_ACK && !e_ack;
      e_req   <= m_debt != 0;
      e_urg   <= m_debt == DM;
      m_debt  <= f_debt(m_debt, f_tick(m_c + 1), REF_ACK);
      if (f_tick(m_c + 1) && !REF_ACK && m_debt == DM)
        e_ovf <= 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, m_c);
  endtask

  always @(negedge CLK) begin
    check("NOP", NOP, e_nop);
    check("READA", READA, e_rda);
    check("WRITEA", WRITEA, e_wra);
    check("SADDR", SADDR, e_saddr);
    check("CMD_ACK", CMD_ACK, e_ack);
    check("PRECHARGE", INIT_PRECHARGE, e_pre);
    check("REFRESH", INIT_REFRESH, e_ref);
    check("LOAD_MODE", INIT_LOAD_MODE, e_lmr);
    check("INIT_DONE", INIT_DONE, e_done);
    check("REF_REQ", REF_REQ, e_req);
    check("REF_URGENT", REF_URGENT, e_urg);
    check("one_hot_init",
          32'(INIT_PRECHARGE + INIT_REFRESH + INIT_LOAD_MODE) <= 1, 1);
`ifdef SDRAM_REF_OVF_EN
    check("REF_OVF", REF_OVF, e_ovf);
`endif
  end

  task automatic go(input int n);
    int guard = 0;
    while (m_c != n && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    if (m_c != n) begin
      n_chk++;
      $display("FAIL go: reached cycle %0d expected %0d", m_c, n);
    end
  endtask

  task automatic pulse_reset();
    #2 RESET_N = 1'b0;
    #1;
    check("arst_done", INIT_DONE, 0);
    check("arst_nop", NOP, 0);
    check("arst_saddr", SADDR, 0);
    check("arst_req", REF_REQ, 0);
    check("arst_ref", INIT_REFRESH, 0);
    @(negedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  logic [2:0] cmd_tbl [8] = '{3'd1, 3'd0, 3'd2, 3'd2,
                              3'd0, 3'd1, 3'd2, 3'd1};
  logic       ack_tbl [8] = '{1'b1, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_nop", NOP, 0);
    check("rst_saddr", SADDR, 0);
    check("rst_done", INIT_DONE, 0);
    #2 RESET_N = 1'b1;

    go(5);  CMD = 3'd1; ADDR = 12'h05A;
    go(6);  check("reada_pre", READA, 0);
            check("nop_pre", NOP, 1); CMD = 3'd0;
    go(13); check("pre_13", INIT_PRECHARGE, 0);
    go(14); check("pre_14", INIT_PRECHARGE, 1);
    go(18); check("ref_18", INIT_REFRESH, 1);
    go(22); check("ref_22", INIT_REFRESH, 1);
    go(26); check("lmr_26", INIT_LOAD_MODE, 1);
            check("done_26", INIT_DONE, 0);
    go(27); check("done_27", INIT_DONE, 1);
    go(30); CM_ACK = 1'b1;
    go(31); check("ack_31", CMD_ACK, 1);
    go(32); check("ack_32", CMD_ACK, 0);
    go(33); check("ack_33", CMD_ACK, 1);
    go(34); check("ack_34", CMD_ACK, 0); CM_ACK = 1'b0;
            check("req_34", REF_REQ, 0);
    go(35); check("req_35", REF_REQ, 1);
    go(40); CMD = 3'd1; ADDR = 12'hABC;
    go(41); check("reada_41", READA, 1);
            check("saddr_41", SADDR, 12'hABC);
            CMD = 3'd2; ADDR = 12'h123;
    go(42); check("writea_42", WRITEA, 1);
            check("urg_42", REF_URGENT, 0); CMD = 3'd0;
    go(43); check("urg_43", REF_URGENT, 1);
    go(51); check("req_51", REF_REQ, 1);
            check("urg_51", REF_URGENT, 1);
`ifdef SDRAM_REF_OVF_EN
            check("ovf_51", REF_OVF, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      go(52 + i);
      CMD     = cmd_tbl[i % 8];
      ADDR    = AW'(i * 291 + 7);
      REF_ACK = ack_tbl[i % 8];
      CM_ACK  = (i % 3) != 0;
    end
    go(68); CMD = 3'd0; REF_ACK = 1'b0; CM_ACK = 1'b0;

    go(75); pulse_reset();
    ADDR = 12'h777;
    go(20); check("saddr_20", SADDR, 12'h777);
    pulse_reset();

    go(13); check("pre2_13", INIT_PRECHARGE, 0);
    go(14); check("pre2_14", INIT_PRECHARGE, 1);
    go(27); check("done2_27", INIT_DONE, 1);
    go(35); check("req2_35", REF_REQ, 1);
    go(41); REF_ACK = 1'b1;
    go(42); REF_ACK = 1'b0;
    go(43); check("req2_43", REF_REQ, 1);
            check("urg2_43", REF_URGENT, 0);
    go(44); REF_ACK = 1'b1;
    go(45); REF_ACK = 1'b0; check("req2_45", REF_REQ, 1);
    go(46); check("req2_46", REF_REQ, 0);
    go(51); check("req2_51", REF_REQ, 1);
    go(55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sdram_ctl_if2.md
SDRAM_CTL_IF2 -- requirements
Module: sdram_ctl_if2

Interface
REQ-001 Parameter ASIZE, default 23: address width.
REQ-002 Parameter INIT_PER, default 1000: power-up wait, in cycles.
REQ-003 Parameter INIT_GAP, default 20: cycles between init commands.
REQ-004 Parameter INIT_REF_CNT, default 8: auto-refreshes in the init sequence; range 1..15.
REQ-005 Parameter REF_PER, default 1560: refresh interval, in cycles.
REQ-006 Parameter REF_DEBT_MAX, default 4: maximum postponed refreshes; range 1..7.
REQ-007 Clock and reset: reset RESET_N, asynchronous, active-low; clock CLK.
REQ-008 CMD  in  3  command code: 000 NOP, 001 READA, 010 WRITEA; other codes are ignored.
REQ-009 ADDR  in  ASIZE  command address.
REQ-010 CM_ACK  in  1  command-done from the command FSM.
REQ-011 REF_ACK  in  1  one refresh issued.
REQ-012 NOP, READA, WRITEA  out  1 each  registered decodes of CMD.
REQ-013 SADDR  out  ASIZE  ADDR registered alongside the decodes.
REQ-014 CMD_ACK  out  1  one-cycle command acknowledge.
REQ-015 INIT_PRECHARGE, INIT_REFRESH, INIT_LOAD_MODE  out  1 each  one-cycle init command pulses.
REQ-016 INIT_DONE  out  1  initialisation complete; sticky.
REQ-017 REF_REQ  out  1  refresh debt is nonzero.
REQ-018 REF_URGENT  out  1  refresh debt equals REF_DEBT_MAX.

Function
REQ-019 Init FSM SHALL use the states WAIT, PRE, REF, LMR and RUN, with a 16-bit cycle counter.
- WAIT: counts INIT_PER cycles.
- PRE, REF and LMR: each waits INIT_GAP cycles, then pulses its output for one cycle.
- REF repeats INIT_REF_CNT times.
- After the LMR pulse the FSM enters RUN.
REQ-020 Init timing, with cycle 0 = first edge after reset release:
- PRECHARGE pulse at INIT_PER+INIT_GAP.
- k-th REFRESH pulse at INIT_PER+(k+1)*INIT_GAP.
- LOAD_MODE pulse at INIT_PER+(INIT_REF_CNT+2)*INIT_GAP.
- INIT_DONE rises the next cycle and stays high until reset.
REQ-021 At most one init pulse SHALL be high in any cycle.
REQ-022 Command decode SHALL have 1-cycle latency, and SADDR SHALL load ADDR every cycle.
REQ-023 While INIT_DONE=0: NOP=1, READA=0, WRITEA=0.
REQ-024 CMD_ACK SHALL be 1 in the cycle after CM_ACK=1 while CMD_ACK=0, and 0 otherwise; a held CM_ACK gives a 1,0,1,0 pattern.
REQ-025 Refresh timer (16-bit) SHALL be idle until INIT_DONE.
- It ticks every REF_PER cycles; the first tick makes REF_REQ rise exactly REF_PER cycles after INIT_DONE rises.
- It free-runs and is not reloaded by REF_ACK.
REQ-026 Refresh debt counter (3-bit) SHALL behave as follows:
- Tick: +1.
- REF_ACK with debt>0: -1.
- Tick and REF_ACK in the same cycle: unchanged.
- REF_ACK with debt=0: ignored.
- Tick at REF_DEBT_MAX: saturates.
REQ-027 REF_REQ and REF_URGENT SHALL be registered decodes of the debt counter, valid the cycle after it changes.
REQ-028 REF_ACK before INIT_DONE SHALL be ignored.

Reset
REQ-029 RESET_N low SHALL asynchronously clear all outputs, counters and the debt, and return the FSM to WAIT.
- SADDR=0 and INIT_DONE=0 in reset.
- Reset mid-init or mid-run restarts the full init sequence.

Configuration
REQ-030 With SDRAM_REF_OVF_EN defined, output REF_OVF (1 bit) SHALL be present.
- Sticky: set when a tick occurs at REF_DEBT_MAX without REF_ACK in that cycle.
- Cleared only by reset.
- Without the macro, the port and its logic are absent and saturation is silent.

Structure
REQ-031 Shared package sdram_pkg SHALL hold the CMD encodings, the init-state enum and the counter widths.
REQ-032 The refresh timer and debt counter SHALL be sub-module sdram_ref_sched; the init FSM and decode stay in the top.

Verification
(all with INIT_PER=10, INIT_GAP=4, INIT_REF_CNT=2, REF_PER=8, REF_DEBT_MAX=2)
REQ-033 Release reset -> PRECHARGE pulse at cycle 14, REFRESH at 18 and 22, LOAD_MODE at 26, INIT_DONE rises at 27.
REQ-034 CMD=001 at cycle 5, then at cycle 40 -> READA=0 at cycle 6; READA=1 at cycle 41 with SADDR matching.
REQ-035 No REF_ACK after INIT_DONE -> REF_REQ rises at cycle 35, REF_URGENT at 43, debt stays at 2 from 51 on (REF_OVF=1 with the macro).
REQ-036 REF_ACK coincident with a tick at debt=1 -> debt stays 1; a second REF_ACK -> REF_REQ=0 next cycle.
REQ-037 CM_ACK held high for 4 cycles -> CMD_ACK pattern 1,0,1,0.
REQ-038 RESET_N pulsed low at cycle 20, released at cycle 21 -> all outputs 0 immediately; PRECHARGE pulse 14 cycles after release.
